// File: rtl/tpg_lfsr_param_if.sv
// Control and pattern bus between the BIST controller (master) and the
// parametrised test-pattern generator (slave).
interface tpg_lfsr_param_if #(
    parameter int WIDTH = 3
);
    logic             start;
    logic             hold;
    logic             abort;
    logic             mode;
    logic [WIDTH-1:0] seed;
    logic [WIDTH:1]   dataout_tpg;
    logic             valid;
    logic             complete;
    logic [WIDTH:0]   pattern_count;

    modport master (
        output start, hold, abort, mode, seed,
        input  dataout_tpg, valid, complete, pattern_count
    );

    modport slave (
        input  start, hold, abort, mode, seed,
        output dataout_tpg, valid, complete, pattern_count
    );
endinterface

// File: rtl/tpg_lfsr_param.sv
// Parametrised BIST test-pattern generator: maximal-length LFSR with optional
// de Bruijn zero insertion, or a binary up-counter, under run/hold/abort control.
module tpg_lfsr_param #(
    parameter int               WIDTH        = 3,
    parameter logic [WIDTH-1:0] TAPS         = 3'b110,
    parameter bit               INCLUDE_ZERO = 1'b1,
    parameter logic [WIDTH-1:0] RESET_SEED   = {{(WIDTH-1){1'b0}}, 1'b1}
) (
    input logic             clock,
    input logic             reset,
    tpg_lfsr_param_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [WIDTH:0] FULL_COUNT = {1'b1, {WIDTH{1'b0}}};
    localparam logic [WIDTH:0] LFSR_COUNT = FULL_COUNT - 1'b1;

    state_t         state;
    logic [WIDTH:1] pattern;
    logic [WIDTH:0] count;
    logic           valid;
    logic           complete;
    logic           mode_q;

    logic           feedback;
    logic [WIDTH:1] lfsr_next;
    logic [WIDTH:1] counter_next;
    logic [WIDTH:1] start_value;
    logic [WIDTH:0] n_pat;

    // Zero insertion flips the feedback whenever the shifted-out bits are all
    // zero, splicing 0 into the cycle right after the 100..0 pattern.
    always_comb begin
        feedback = ^(pattern & TAPS);
        if (INCLUDE_ZERO && (pattern[WIDTH-1:1] == '0)) begin
            feedback = ~feedback;
        end
        lfsr_next    = {pattern[WIDTH-1:1], feedback};
        counter_next = pattern + 1'b1;
        start_value  = bus.seed;
        if (!bus.mode && !INCLUDE_ZERO && (bus.seed == '0)) begin
            start_value = {{(WIDTH-1){1'b0}}, 1'b1};
        end
        n_pat = (mode_q || INCLUDE_ZERO) ? FULL_COUNT : LFSR_COUNT;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            pattern  <= RESET_SEED;
            count    <= '0;
            valid    <= 1'b0;
            complete <= 1'b0;
            mode_q   <= 1'b0;
        end else if (bus.abort) begin
            state    <= IDLE;
            count    <= '0;
            valid    <= 1'b0;
            complete <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    valid <= 1'b0;
                    if (bus.start) begin
                        state    <= RUN;
                        pattern  <= start_value;
                        count    <= {{WIDTH{1'b0}}, 1'b1};
                        valid    <= 1'b1;
                        complete <= 1'b0;
                        mode_q   <= bus.mode;
                    end
                end
                RUN: begin
                    if (bus.hold) begin
                        valid <= 1'b0;
                    end else if (count == n_pat) begin
                        state    <= DONE;
                        valid    <= 1'b0;
                        complete <= 1'b1;
                    end else begin
                        pattern <= mode_q ? counter_next : lfsr_next;
                        count   <= count + 1'b1;
                        valid   <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.dataout_tpg   = pattern;
    assign bus.valid         = valid;
    assign bus.complete      = complete;
    assign bus.pattern_count = count;
endmodule

// File: tb/tb_tpg_lfsr_param.sv
// Scoreboard bench for tpg_lfsr_param: two 3-bit instances (without and with
// zero insertion) share one stimulus stream and are checked against a table model.
module tb_tpg_lfsr_param;
    localparam int WIDTH = 3;

    typedef struct packed {
        logic [2:0] pattern;
        logic [3:0] count;
    } exp_t;

    logic       clock = 1'b0;
    logic       reset;
    logic       start;
    logic       hold;
    logic       abort;
    logic       mode;
    logic [2:0] seed;

    int checks = 0;
    int errors = 0;

    exp_t q0[$];
    exp_t q1[$];

    // Successor order of the maximal 3-bit sequence for taps 110.
    logic [2:0] lfsr_order [7] = '{3'b001, 3'b010, 3'b101, 3'b011, 3'b111, 3'b110, 3'b100};

    int         st        [2];
    int         emitted   [2];
    logic [2:0] last_pat  [2];
    bit         run_mode  [2];
    bit         exp_valid [2];

    tpg_lfsr_param_if #(.WIDTH(WIDTH)) bus0 ();
    tpg_lfsr_param_if #(.WIDTH(WIDTH)) bus1 ();

    assign bus0.start = start;
    assign bus0.hold  = hold;
    assign bus0.abort = abort;
    assign bus0.mode  = mode;
    assign bus0.seed  = seed;
    assign bus1.start = start;
    assign bus1.hold  = hold;
    assign bus1.abort = abort;
    assign bus1.mode  = mode;
    assign bus1.seed  = seed;

    tpg_lfsr_param #(
        .WIDTH(WIDTH), .TAPS(3'b110), .INCLUDE_ZERO(1'b0), .RESET_SEED(3'b001)
    ) dut0 (
        .clock(clock), .reset(reset), .bus(bus0)
    );

    tpg_lfsr_param #(
        .WIDTH(WIDTH), .TAPS(3'b110), .INCLUDE_ZERO(1'b1), .RESET_SEED(3'b001)
    ) dut1 (
        .clock(clock), .reset(reset), .bus(bus1)
    );

    always #5 clock = ~clock;

    function automatic logic [2:0] model_next(input logic [2:0] p, input bit counting, input bit incz);
        if (counting) return p + 3'd1;
        if (incz && p == 3'b100) return 3'b000;
        if (incz && p == 3'b000) return 3'b001;
        for (int k = 0; k < 7; k++) begin
            if (lfsr_order[k] == p) return lfsr_order[(k + 1) % 7];
        end
        return 3'b000;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            st[d]        = 0;
            emitted[d]   = 0;
            last_pat[d]  = 3'b001;
            run_mode[d]  = 1'b0;
            exp_valid[d] = 1'b0;
        end
    endtask

    task automatic push_expected(input int d);
        exp_t e;
        e.pattern = last_pat[d];
        e.count   = 4'(emitted[d]);
        if (d == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    // st: 0 idle, 1 running, 2 done; instance 1 is the zero-inserting one.
    task automatic model_step(input int d, input bit go, input bit hl, input bit ab,
                              input bit md, input logic [2:0] sd);
        int n;
        exp_valid[d] = 1'b0;
        if (ab) begin
            st[d]      = 0;
            emitted[d] = 0;
        end else if (st[d] != 1) begin
            if (go) begin
                run_mode[d]  = md;
                last_pat[d]  = (!md && d == 0 && sd == 3'b000) ? 3'b001 : sd;
                emitted[d]   = 1;
                st[d]        = 1;
                exp_valid[d] = 1'b1;
                push_expected(d);
            end
        end else if (!hl) begin
            n = (run_mode[d] || d == 1) ? 8 : 7;
            if (emitted[d] == n) begin
                st[d] = 2;
            end else begin
                last_pat[d]  = model_next(last_pat[d], run_mode[d], d == 1);
                emitted[d]   = emitted[d] + 1;
                exp_valid[d] = 1'b1;
                push_expected(d);
            end
        end
    endtask

    task automatic check_value(input string name, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic checkOutput();
        check_value("dut0_valid",    8'(bus0.valid),         8'(exp_valid[0]));
        check_value("dut0_complete", 8'(bus0.complete),      8'(st[0] == 2));
        check_value("dut0_count",    8'(bus0.pattern_count), 8'(emitted[0]));
        check_value("dut0_pattern",  8'(bus0.dataout_tpg),   8'(last_pat[0]));
        check_value("dut1_valid",    8'(bus1.valid),         8'(exp_valid[1]));
        check_value("dut1_complete", 8'(bus1.complete),      8'(st[1] == 2));
        check_value("dut1_count",    8'(bus1.pattern_count), 8'(emitted[1]));
        check_value("dut1_pattern",  8'(bus1.dataout_tpg),   8'(last_pat[1]));
    endtask

    task automatic applyStimulus(input bit go, input bit hl, input bit ab,
                                 input bit md, input logic [2:0] sd);
        @(negedge clock);
        #1;
        checkOutput();
        start = go;
        hold  = hl;
        abort = ab;
        mode  = md;
        seed  = sd;
        model_step(0, go, hl, ab, md, sd);
        model_step(1, go, hl, ab, md, sd);
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 3'b000);
    endtask

    task automatic reset_mid_run();
        @(negedge clock);
        #2;
        start = 1'b0;
        hold  = 1'b0;
        abort = 1'b0;
        reset = 1'b0;
        #1;
        check_value("rst_dut0_pattern",  8'(bus0.dataout_tpg),   8'h01);
        check_value("rst_dut0_valid",    8'(bus0.valid),         8'h00);
        check_value("rst_dut0_complete", 8'(bus0.complete),      8'h00);
        check_value("rst_dut0_count",    8'(bus0.pattern_count), 8'h00);
        check_value("rst_dut1_pattern",  8'(bus1.dataout_tpg),   8'h01);
        check_value("rst_dut1_count",    8'(bus1.pattern_count), 8'h00);
        model_reset();
        q0.delete();
        q1.delete();
        @(negedge clock);
        #2;
        reset = 1'b1;
    endtask

    task automatic pop_compare(input int d, input logic [2:0] data, input logic [3:0] cnt);
        exp_t e;
        int   depth;
        depth = (d == 0) ? q0.size() : q1.size();
        checks++;
        if (depth == 0) begin
            errors++;
            $display("[TB] FAIL dut%0d_unexpected_valid: got pattern %b count %0d, required no valid", d, data, cnt);
            return;
        end
        if (d == 0) e = q0.pop_front();
        else        e = q1.pop_front();
        checks++;
        if (data !== e.pattern || cnt !== e.count) begin
            errors++;
            $display("[TB] FAIL dut%0d_sequence: got pattern %b count %0d, required pattern %b count %0d",
                     d, data, cnt, e.pattern, e.count);
        end
    endtask

    initial begin
        forever begin
            @(negedge clock);
            if (bus0.valid === 1'b1) pop_compare(0, bus0.dataout_tpg, bus0.pattern_count);
            if (bus1.valid === 1'b1) pop_compare(1, bus1.dataout_tpg, bus1.pattern_count);
        end
    end

    initial begin
        reset = 1'b0;
        start = 1'b0;
        hold  = 1'b0;
        abort = 1'b0;
        mode  = 1'b0;
        seed  = 3'b000;
        model_reset();
        repeat (2) @(negedge clock);
        #2;
        reset = 1'b1;

        $display("[TB] LFSR from seed 001");
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 3'b001);
        idle(10);

        $display("[TB] counter from seed 110");
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 3'b110);
        idle(10);

        $display("[TB] LFSR from seed 000");
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 3'b000);
        idle(10);

        $display("[TB] hold after 011, stray start while running");
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 3'b001);
        idle(3);
        repeat (3) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 3'b000);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 3'b111);
        idle(8);

        $display("[TB] async reset after 101");
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 3'b001);
        idle(2);
        reset_mid_run();
        idle(2);

        $display("[TB] abort with start and hold, then restart");
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 3'b001);
        idle(2);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 3'b101);
        idle(3);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 3'b001);
        idle(10);

        $display("[TB] randomized runs");
        for (int r = 0; r < 20; r++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 1'($urandom_range(1)), 3'($urandom_range(7)));
            for (int c = 0; c < 40; c++) begin
                applyStimulus($urandom_range(15) == 0, $urandom_range(3) == 0,
                              $urandom_range(49) == 0, 1'($urandom_range(1)),
                              3'($urandom_range(7)));
            end
        end
        idle(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
